// File: rtl/shift_rows_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : shift_rows_pipe
//  Purpose  : Registered Rijndael ShiftRows / InvShiftRows stage with a
//             valid/ready handshake, a per-block mode bit and a sideband tag.
//             Supports states of NB = 4, 6 or 8 columns.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NB     state columns (4, 6 or 8)
//    TAG_W  sideband tag width (>= 1), passed through unchanged
//  Ports
//    clk, rst              rising-edge clock, synchronous active-high reset
//    in_valid/in_ready     input handshake
//    in_mode               0 = ShiftRows, 1 = InvShiftRows
//    in_tag, in_data       sideband tag, state (byte 0 in the MSBs)
//    out_valid/out_ready   output handshake
//    out_mode, out_tag     mode and tag of the presented block
//    out_data              shifted state (byte 0 in the MSBs)
//  Build option
//    SHIFT_ROWS_IN_REG_EN  adds an input register stage (latency 2)
// ============================================================================
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic [32*NB-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_mode,
    output logic [TAG_W-1:0]    out_tag,
    output logic [32*NB-1:0]    out_data
);

    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    // Block feeding the permutation / output register
    logic             w_src_valid;
    logic             w_src_mode;
    logic [TAG_W-1:0] w_src_tag;
    logic [W-1:0]     w_src_data;

    logic [W-1:0]     w_fwd;
    logic [W-1:0]     w_inv;
    logic [W-1:0]     w_perm;
    logic             w_out_load;

    logic             r_out_valid;
    logic             r_out_mode;
    logic [TAG_W-1:0] r_out_tag;
    logic [W-1:0]     r_out_data;

    // Byte k = 4*c + r lives in the k-th byte from the MSB end. Each output
    // byte is a fixed wire from one source byte, so the permutation is pure
    // routing plus a 2:1 mux on mode.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // Row offsets are 0,1,2,3 except NB=8 where rows 2,3 skip to 3,4
            localparam int OFS   = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int SRC_F = (c + OFS) % NB;
            localparam int SRC_I = (c - OFS + NB) % NB;
            assign w_fwd[W-8-8*(4*c+r) +: 8] = w_src_data[W-8-8*(4*SRC_F+r) +: 8];
            assign w_inv[W-8-8*(4*c+r) +: 8] = w_src_data[W-8-8*(4*SRC_I+r) +: 8];
        end
    end

    assign w_perm = w_src_mode ? w_inv : w_fwd;

    // Output register accepts when empty or being drained this cycle
    assign w_out_load = w_src_valid && (!r_out_valid || out_ready);

`ifdef SHIFT_ROWS_IN_REG_EN
    logic             r_s0_valid;
    logic             r_s0_mode;
    logic [TAG_W-1:0] r_s0_tag;
    logic [W-1:0]     r_s0_data;

    // Stage 0 advances exactly when the output register loads from it
    assign in_ready    = !r_s0_valid || w_out_load;
    assign w_src_valid = r_s0_valid;
    assign w_src_mode  = r_s0_mode;
    assign w_src_tag   = r_s0_tag;
    assign w_src_data  = r_s0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_mode  <= 1'b0;
            r_s0_tag   <= '0;
            r_s0_data  <= '0;
        end else if (in_valid && in_ready) begin
            r_s0_valid <= 1'b1;
            r_s0_mode  <= in_mode;
            r_s0_tag   <= in_tag;
            r_s0_data  <= in_data;
        end else if (w_out_load) begin
            r_s0_valid <= 1'b0;
        end
    end
`else
    assign in_ready    = !r_out_valid || out_ready;
    assign w_src_valid = in_valid;
    assign w_src_mode  = in_mode;
    assign w_src_tag   = in_tag;
    assign w_src_data  = in_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_mode  <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
        end else if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_out_mode  <= w_src_mode;
            r_out_tag   <= w_src_tag;
            r_out_data  <= w_perm;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_mode  = r_out_mode;
    assign out_tag   = r_out_tag;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire
